// File: rtl/data_mem_arbiter.sv
// Two-port round-robin front end for a single-ported data memory.
// Handles one access at a time, with range checking and read-modify-write for sub-double stores.
module data_mem_arbiter #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_addr,
  input  logic        req0_we,
  input  logic [1:0]  req0_size,
  input  logic        req0_unsigned,
  input  logic [63:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_addr,
  input  logic        req1_we,
  input  logic [1:0]  req1_size,
  input  logic        req1_unsigned,
  input  logic [63:0] req1_wdata,
  output logic        resp0_valid,
  output logic [63:0] resp0_rdata,
  output logic        resp0_err,
  output logic        resp1_valid,
  output logic [63:0] resp1_rdata,
  output logic        resp1_err,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  output logic        mem_write_en,
  output logic        mem_read_en,
  input  logic [63:0] mem_read_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  typedef struct packed {
    logic        port;
    logic [63:0] addr;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] wdata;
    logic        err;
  } acc_t;

  logic [1:0]  state;
  logic        last_gnt;
  acc_t        acc_q, acc_n;
  logic [63:0] rd_q, merged, ext;
  logic [7:0]  bmask;
  logic        gnt, fire, idle, in_resp;

  assign idle       = !rst && state == IDLE;
  assign gnt        = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
  assign req0_ready = idle && req0_valid && !gnt;
  assign req1_ready = idle && req1_valid && gnt;
  assign fire       = req0_ready || req1_ready;

  always_comb begin
    acc_n       = '0;
    acc_n.port  = gnt;
    acc_n.addr  = gnt ? req1_addr     : req0_addr;
    acc_n.we    = gnt ? req1_we       : req0_we;
    acc_n.size  = gnt ? req1_size     : req0_size;
    acc_n.uns   = gnt ? req1_unsigned : req0_unsigned;
    acc_n.wdata = gnt ? req1_wdata    : req0_wdata;
    // 65-bit sum so addresses near 2^64 cannot wrap back into range
    acc_n.err   = ({1'b0, acc_n.addr} + 65'd7) > (65'(MEM_BYTES) - 65'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      acc_q    <= '0;
      rd_q     <= '0;
    end else begin
      case (state)
        IDLE: if (fire) begin
          acc_q    <= acc_n;
          last_gnt <= acc_n.port;
          if (acc_n.err)                   state <= RESP;
          else if (acc_n.we && &acc_n.size) state <= WRITE;
          else                              state <= READ;
        end
        READ: begin
          rd_q  <= mem_read_data;
          state <= acc_q.we ? WRITE : RESP;
        end
        WRITE:   state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (acc_q.size)
      2'd0:    bmask = 8'h01;
      2'd1:    bmask = 8'h03;
      2'd2:    bmask = 8'h0f;
      default: bmask = 8'hff;
    endcase
  end

  for (genvar i = 0; i < 8; i++) begin : g_merge
    assign merged[8*i +: 8] = bmask[i] ? acc_q.wdata[8*i +: 8] : rd_q[8*i +: 8];
  end

  always_comb begin
    case (acc_q.size)
      2'd0:    ext = {{56{!acc_q.uns && rd_q[7]}},  rd_q[7:0]};
      2'd1:    ext = {{48{!acc_q.uns && rd_q[15]}}, rd_q[15:0]};
      2'd2:    ext = {{32{!acc_q.uns && rd_q[31]}}, rd_q[31:0]};
      default: ext = rd_q;
    endcase
  end

  assign mem_read_en    = !rst && state == READ;
  assign mem_write_en   = !rst && state == WRITE;
  assign mem_address    = (mem_read_en || mem_write_en) ? acc_q.addr : '0;
  assign mem_write_data = mem_write_en ? merged : '0;

  assign in_resp     = !rst && state == RESP;
  assign resp0_valid = in_resp && !acc_q.port;
  assign resp1_valid = in_resp && acc_q.port;
  assign resp0_err   = resp0_valid && acc_q.err;
  assign resp1_err   = resp1_valid && acc_q.err;
  assign resp0_rdata = (resp0_valid && !acc_q.we && !acc_q.err) ? ext : '0;
  assign resp1_rdata = (resp1_valid && !acc_q.we && !acc_q.err) ? ext : '0;

endmodule
